// File: rtl/clock_timekeeper_if.sv
// Command/status bundle between the watch mode machine and the timekeeper.
// The master drives edit commands and field selects; the slave returns BCD time, tick and blanking.
interface clock_timekeeper_if;
  logic       sec_reset;
  logic       min_inc;
  logic       hour_inc;
  logic       sec_onoff;
  logic       min_onoff;
  logic       hour_onoff;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       tick_1hz;
  logic       sec_blank;
  logic       min_blank;
  logic       hour_blank;

  modport master (
    output sec_reset, min_inc, hour_inc, sec_onoff, min_onoff, hour_onoff,
    input  sec_bcd, min_bcd, hour_bcd, tick_1hz, sec_blank, min_blank, hour_blank
  );

  modport slave (
    input  sec_reset, min_inc, hour_inc, sec_onoff, min_onoff, hour_onoff,
    output sec_bcd, min_bcd, hour_bcd, tick_1hz, sec_blank, min_blank, hour_blank
  );
endinterface

// File: rtl/clock_timekeeper.sv
// Watch timekeeper: 1 Hz prescaler, BCD hh:mm:ss chain with edit commands.
// Optional field blinking is compiled in when the BLINK_EN macro is defined.
module clock_timekeeper #(
  parameter int PRESCALE = 1000
`ifdef BLINK_EN
  ,
  parameter int BLINK_HALF = PRESCALE / 2
`endif
) (
  input logic               ck,
  input logic               sysreset,
  clock_timekeeper_if.slave bus
);
  localparam int            PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [7:0]    r_sec;
  logic [7:0]    r_min;
  logic [7:0]    r_hour;
  logic [7:0]    w_sec_nxt;
  logic [7:0]    w_min_nxt;
  logic [7:0]    w_hour_nxt;
  logic          r_sec_reset_d;
  logic          r_min_inc_d;
  logic          r_hour_inc_d;
  logic          w_sec_fire;
  logic          w_min_fire;
  logic          w_hour_fire;
  logic          w_tick;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic [8:0]    w_sec_inc;
  logic [8:0]    w_min_inc;
  logic [8:0]    w_hour_inc;

  // Returns {wrap, next}: wraps to 00 at tens_max/units_max, else per-digit BCD +1.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                         input logic [3:0] tens_max,
                                         input logic [3:0] units_max);
    logic [8:0] res;
    if ((v[7:4] == tens_max) && (v[3:0] == units_max)) begin
      res = {1'b1, 8'h00};
    end else if (v[3:0] == 4'd9) begin
      res = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      res = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  assign w_sec_fire  = bus.sec_reset & ~r_sec_reset_d;
  assign w_min_fire  = bus.min_inc & ~r_min_inc_d;
  assign w_hour_fire = bus.hour_inc & ~r_hour_inc_d;
  assign w_tick      = (r_presc == PRESC_LAST) & ~bus.sec_onoff;
  assign w_sec_inc   = bcd_inc(r_sec, 4'd5, 4'd9);
  assign w_min_inc   = bcd_inc(r_min, 4'd5, 4'd9);
  assign w_hour_inc  = bcd_inc(r_hour, 4'd2, 4'd3);

  // Next-state for prescaler and counter chain; an edit on a field replaces any carry into it.
  always_comb begin
    w_presc_nxt = r_presc;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hour_nxt  = r_hour;
    w_sec_carry = w_tick & w_sec_inc[8] & ~w_sec_fire;
    w_min_carry = w_sec_carry & w_min_inc[8] & ~w_min_fire;

    if (bus.sec_onoff || w_sec_fire) begin
      w_presc_nxt = '0;
    end else if (r_presc == PRESC_LAST) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end

    if (w_sec_fire) begin
      w_sec_nxt = 8'h00;
    end else if (w_tick) begin
      w_sec_nxt = w_sec_inc[7:0];
    end else begin
      w_sec_nxt = r_sec;
    end

    if (w_min_fire || w_sec_carry) begin
      w_min_nxt = w_min_inc[7:0];
    end else begin
      w_min_nxt = r_min;
    end

    if (w_hour_fire || w_min_carry) begin
      w_hour_nxt = w_hour_inc[7:0];
    end else begin
      w_hour_nxt = r_hour;
    end
  end

  // Time, prescaler and command history registers.
  always_ff @(posedge ck or posedge sysreset) begin
    if (sysreset) begin
      r_presc       <= '0;
      r_sec         <= 8'h00;
      r_min         <= 8'h00;
      r_hour        <= 8'h00;
      r_sec_reset_d <= 1'b0;
      r_min_inc_d   <= 1'b0;
      r_hour_inc_d  <= 1'b0;
    end else begin
      r_presc       <= w_presc_nxt;
      r_sec         <= w_sec_nxt;
      r_min         <= w_min_nxt;
      r_hour        <= w_hour_nxt;
      r_sec_reset_d <= bus.sec_reset;
      r_min_inc_d   <= bus.min_inc;
      r_hour_inc_d  <= bus.hour_inc;
    end
  end

  assign bus.sec_bcd  = r_sec;
  assign bus.min_bcd  = r_min;
  assign bus.hour_bcd = r_hour;
  assign bus.tick_1hz = w_tick;

`ifdef BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          w_blink_clr;

  // Restart blinking from the visible phase after an edit or when nothing is selected.
  assign w_blink_clr = w_sec_fire | w_min_fire | w_hour_fire |
                       ~(bus.sec_onoff | bus.min_onoff | bus.hour_onoff);

  // Blink half-period counter and phase toggle.
  always_ff @(posedge ck or posedge sysreset) begin
    if (sysreset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_blink_clr) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BW'(1);
      r_blink_phase <= r_blink_phase;
    end
  end

  assign bus.sec_blank  = bus.sec_onoff & r_blink_phase;
  assign bus.min_blank  = bus.min_onoff & r_blink_phase;
  assign bus.hour_blank = bus.hour_onoff & r_blink_phase;
`else
  assign bus.sec_blank  = 1'b0;
  assign bus.min_blank  = 1'b0;
  assign bus.hour_blank = 1'b0;
`endif
endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper at PRESCALE=4; blink checks follow the BLINK_EN macro.
module tb_clock_timekeeper;
  logic ck = 1'b0;
  logic sysreset;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  clock_timekeeper_if bus ();

  clock_timekeeper #(.PRESCALE(4)) dut (
    .ck       (ck),
    .sysreset (sysreset),
    .bus      (bus.slave)
  );

  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic pulse_min();
    bus.min_inc = 1'b1;
    step();
    bus.min_inc = 1'b0;
    step();
  endtask

  task automatic pulse_hour();
    bus.hour_inc = 1'b1;
    step();
    bus.hour_inc = 1'b0;
    step();
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, bus.hour_bcd, to_bcd(h));
    chk({tag, "_min"}, bus.min_bcd, to_bcd(m));
    chk({tag, "_sec"}, bus.sec_bcd, to_bcd(s));
  endtask

  initial begin
    logic exp_blank;
    bus.sec_reset  = 1'b0;
    bus.min_inc    = 1'b0;
    bus.hour_inc   = 1'b0;
    bus.sec_onoff  = 1'b0;
    bus.min_onoff  = 1'b0;
    bus.hour_onoff = 1'b0;
    sysreset       = 1'b1;
    #12;
    chk_time("reset", 0, 0, 0);
    chk("reset_tick", {7'd0, bus.tick_1hz}, 8'h00);
    chk("reset_blank", {5'd0, bus.sec_blank, bus.min_blank, bus.hour_blank}, 8'h00);
    @(posedge ck);
    #1;
    sysreset = 1'b0;

    // Free run for one minute: tick on every 4th cycle, seconds follow.
    for (int i = 1; i <= 240; i++) begin
      step();
      chk("run_tick", {7'd0, bus.tick_1hz}, (i % 4 == 3) ? 8'h01 : 8'h00);
      chk("run_sec", bus.sec_bcd, to_bcd((i / 4) % 60));
    end
    chk_time("run_end", 0, 1, 0);

    // Preload 23:59 via edits, seconds frozen, then run seconds to 59 and roll over.
    bus.sec_onoff = 1'b1;
    step();
    repeat (58) pulse_min();
    repeat (23) pulse_hour();
    chk_time("preload", 23, 59, 0);
    bus.sec_onoff = 1'b0;
    repeat (236) step();
    chk_time("pre_roll", 23, 59, 59);
    repeat (3) step();
    chk("roll_tick", {7'd0, bus.tick_1hz}, 8'h01);
    step();
    chk_time("rollover", 0, 0, 0);

    // Edit wraps without carrying into the next field.
    bus.sec_onoff = 1'b1;
    repeat (59) pulse_min();
    chk("min59", bus.min_bcd, 8'h59);
    pulse_min();
    chk_time("min_wrap", 0, 0, 0);
    repeat (23) pulse_hour();
    chk("hour23", bus.hour_bcd, 8'h23);
    pulse_hour();
    chk_time("hour_wrap", 0, 0, 0);

    // Holding min_inc high fires once.
    bus.min_inc = 1'b1;
    repeat (20) step();
    chk("hold_min", bus.min_bcd, 8'h01);
    bus.min_inc = 1'b0;
    step();
    chk("hold_min_rel", bus.min_bcd, 8'h01);

    // Freeze seconds with sec_onoff.
    bus.sec_onoff = 1'b0;
    repeat (12) step();
    chk("sec3", bus.sec_bcd, 8'h03);
    bus.sec_onoff = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("freeze_sec", bus.sec_bcd, 8'h03);
      chk("freeze_tick", {7'd0, bus.tick_1hz}, 8'h00);
    end
    bus.sec_reset = 1'b1;
    step();
    chk("sec_reset", bus.sec_bcd, 8'h00);
    bus.sec_reset = 1'b0;
    bus.sec_onoff = 1'b0;
    step();
    step();
    chk("presc2_tick", {7'd0, bus.tick_1hz}, 8'h00);
    bus.sec_reset = 1'b1;
    step();
    chk("presc_clr_tick", {7'd0, bus.tick_1hz}, 8'h00);
    chk("presc_clr_sec", bus.sec_bcd, 8'h00);
    bus.sec_reset = 1'b0;
    step();
    step();
    chk("presc_clr_t2", {7'd0, bus.tick_1hz}, 8'h00);
    step();
    chk("presc_clr_t3", {7'd0, bus.tick_1hz}, 8'h01);
    step();
    chk("after_clr_sec", bus.sec_bcd, 8'h01);

    // Tick carry out of 59 collides with a min_inc edge: net +1.
    bus.sec_onoff = 1'b1;
    repeat (9) pulse_min();
    chk("min10", bus.min_bcd, 8'h10);
    bus.sec_reset = 1'b1;
    step();
    bus.sec_reset = 1'b0;
    step();
    bus.sec_onoff = 1'b0;
    repeat (236) step();
    chk("coll_sec59", bus.sec_bcd, 8'h59);
    repeat (3) step();
    chk("coll_tick", {7'd0, bus.tick_1hz}, 8'h01);
    bus.min_inc = 1'b1;
    step();
    chk_time("collision", 0, 11, 0);
    bus.min_inc = 1'b0;
    step();

    // Blink on the minutes field.
    bus.min_onoff = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
`ifdef BLINK_EN
      exp_blank = ((k / 2) % 2) == 1;
`else
      exp_blank = 1'b0;
`endif
      chk("min_blank", {7'd0, bus.min_blank}, {7'd0, exp_blank});
      chk("other_blank", {6'd0, bus.sec_blank, bus.hour_blank}, 8'h00);
    end
    bus.min_inc = 1'b1;
    step();
    chk("blank_edit", {7'd0, bus.min_blank}, 8'h00);
    bus.min_inc   = 1'b0;
    bus.min_onoff = 1'b0;
    step();

    // Asynchronous reset between clock edges.
    step();
    #2;
    sysreset = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst_tick", {7'd0, bus.tick_1hz}, 8'h00);
    step();
    sysreset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
Timekeeping datapath and sequencer for the digital watch. It divides the system clock down to a 1 Hz tick and runs the BCD seconds/minutes/hours counter chain with carries. It applies the edit commands produced by the mode state machine (sec_reset, min_inc, hour_inc) and the field-select levels (sec_onoff, min_onoff, hour_onoff). It drives BCD time and per-field blanking to the display driver.

Parameters:
PRESCALE, 1000, ck cycles per second; must be ≥ 4 and even.
BLINK_HALF, PRESCALE/2, ck cycles per blink half-period; used only with BLINK_EN.

Ports:
ck  input  1  system clock, rising edge
sysreset  input  1  reset, asynchronous, active-high
sec_reset  input  1  level; request to clear seconds; acted on at its rising edge
min_inc  input  1  level; request to increment minutes; acted on at its rising edge
hour_inc  input  1  level; request to increment hours; acted on at its rising edge
sec_onoff  input  1  seconds field selected for editing
min_onoff  input  1  minutes field selected for editing
hour_onoff  input  1  hours field selected for editing
sec_bcd  output  8  seconds, two BCD digits, 00..59
min_bcd  output  8  minutes, two BCD digits, 00..59
hour_bcd  output  8  hours, two BCD digits, 00..23
tick_1hz  output  1  one-cycle pulse, once per second
sec_blank  output  1  blank seconds digits
min_blank  output  1  blank minutes digits
hour_blank  output  1  blank hours digits

Behaviour:
- Reset: sysreset is asynchronous and active-high.
  - All BCD outputs are 8'h00 on reset.
  - Prescaler is 0 on reset.
  - tick_1hz is 0 on reset.
  - All blank outputs are 0 on reset.
  - Edge-detect history registers are 0 on reset.
  - Blink phase is 0 on reset.
  - Asserting reset mid-count aborts everything immediately, with no pending carries.
- Edge detect:
  - Each command input is registered every cycle.
  - A command is "fired" in the cycle where input=1 and its registered copy=0.
  - Holding a command high fires exactly once.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick_1hz = (prescaler == PRESCALE-1) and sec_onoff==0. It is a combinational decode of registered state.
  - The counter update happens on the clock edge that ends the tick cycle.
- While sec_onoff=1:
  - Prescaler is held at 0.
  - Seconds are frozen.
  - No tick is produced.
- Counter chain on a tick:
  - Seconds: BCD +1. 59 → 00 with carry to minutes.
  - Minutes: 59 → 00 with carry to hours.
  - Hours: 23 → 00 with no further carry.
  - Arithmetic is per-digit BCD:
    - Units 9 → 0 increments the tens digit.
    - Tens is bounded by the field limit.
  - Non-BCD codes never occur; the implementation need not handle them.
- Edits:
  - sec_reset fired: seconds ← 00 and prescaler ← 0. No carry into minutes.
  - min_inc fired: minutes +1, wrapping 59 → 00 with NO carry into hours.
  - hour_inc fired: hours +1, wrapping 23 → 00.
  - Edits act regardless of the onoff levels; the mode machine gates them.
- Simultaneous events in one cycle:
  - An edit on a field overrides a carry into that same field. Net change is +1 (or clear), never +2.
  - Lower fields still update normally; e.g. the seconds 59 → 00 wrap still happens.
  - A carry out of an edited field is suppressed.
  - Multiple edits fired together are all applied independently.
- Latency: fired edits and ticks are visible on the BCD outputs one cycle after the firing/tick cycle.
- No internal state machine beyond the counters. The blink phase is a 1-bit toggle.

Optional Feature:
BLINK_EN
- Defined:
  - A blink counter runs 0..BLINK_HALF-1 and toggles blink_phase at each wrap.
  - Each x_blank = x_onoff & blink_phase.
  - Any fired edit clears the blink counter and blink_phase, so the edited field is shown immediately.
  - The blink counter is also cleared whenever no onoff input is high.
- Undefined: blink logic is absent and all blank outputs are constant 0.

Test Plan:
- Reset/run (PRESCALE=4): release reset, run 4·60 cycles → sec_bcd 00..59 then 00, min_bcd=01; tick_1hz pulses every 4th cycle.
- Full rollover: preload via edits to 23:59 with seconds at 59, then one tick → hour_bcd=00, min_bcd=00, sec_bcd=00.
- Edit wraps without carry: min=59, pulse min_inc → min_bcd=00 with hours unchanged. hour=23, pulse hour_inc → hour_bcd=00.
- Hold and freeze: hold min_inc high 20 cycles → +1 only. Hold sec_onoff=1 for 40 cycles → sec_bcd unchanged and no tick; a sec_reset edge → sec_bcd=00, prescaler=0.
- Collision: sec=59 with tick cycle coincident with a min_inc edge, min=10 → min_bcd=11 (not 12), sec_bcd=00.
- BLINK_EN (BLINK_HALF=2): min_onoff=1 → min_blank toggles every 2 cycles and the other blanks stay 0. min_inc edge → min_blank=0 next cycle. Without the macro, all blanks stay 0.
